adc_uart_dump: RTL and testbench

ADC_UART_DUMP -- requirements
Module: adc_uart_dump

---
 rtl/adc_uart_dump_if.sv | 16 +
 rtl/adc_uart_dump.sv | 127 ++++++++++++
 tb/tb_adc_uart_dump.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_uart_dump_if.sv
// Sample-RAM read port and UART transmit handshake for adc_uart_dump.
// master = dump engine (drives address and tx byte), slave = RAM/UART side.
interface adc_uart_dump_if #(
   parameter int UART_WIDTH = 8,
   parameter int ADC_WIDTH  = 12,
   parameter int ADDR       = 11
);
   logic [ADDR-1:0]       ram_addr;
   logic [ADC_WIDTH-1:0]  ram_dout;
   logic [UART_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;

   modport master (output ram_addr, tx_data, tx_valid, input ram_dout, tx_ready);
   modport slave  (input ram_addr, tx_data, tx_valid, output ram_dout, tx_ready);
endinterface

// File: rtl/adc_uart_dump.sv
// Streams DEPTH samples from a sample RAM to a UART as hi/lo byte pairs on a command edge.
// Optional trailing mod-256 checksum byte when ADC_DUMP_CHECKSUM_EN is defined.
module adc_uart_dump #(
   parameter int                    UART_WIDTH = 8,
   parameter int                    ADC_WIDTH  = 12,
   parameter int                    ADDR       = 11,
   parameter int                    DEPTH      = 2048,
   parameter logic [UART_WIDTH-1:0] DUMP_CMD   = 8'h44
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [UART_WIDTH-1:0] command,
   adc_uart_dump_if.master       bus,
   output logic                  busy,
   output logic [UART_WIDTH-1:0] status
);

   localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_WAIT, SEND_HI, SEND_LO,
`ifdef ADC_DUMP_CHECKSUM_EN
      SEND_CK,
`endif
      DONE
   } state_t;

   state_t                state, nxt;
   logic [ADDR-1:0]       counter;
   logic [ADC_WIDTH-1:0]  sample;
   logic                  prev_is_cmd;
   logic                  start;
   logic                  xfer;
   logic                  last;

   // prev_is_cmd resets high so a command held through reset is not an edge
   assign start = (command == DUMP_CMD) && !prev_is_cmd && (state == IDLE || state == DONE);
   assign xfer  = bus.tx_valid && bus.tx_ready;
   assign last  = (counter == LAST);
   assign bus.ram_addr = counter;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: if (start) nxt = RD_ADDR;
         RD_ADDR:    nxt = RD_WAIT;
         RD_WAIT:    nxt = SEND_HI;
         SEND_HI:    if (bus.tx_ready) nxt = SEND_LO;
         SEND_LO: begin
            if (bus.tx_ready) begin
`ifdef ADC_DUMP_CHECKSUM_EN
               nxt = last ? SEND_CK : RD_ADDR;
`else
               nxt = last ? DONE : RD_ADDR;
`endif
            end
         end
`ifdef ADC_DUMP_CHECKSUM_EN
         SEND_CK:    if (bus.tx_ready) nxt = DONE;
`endif
         default:    nxt = IDLE;
      endcase
   end

`ifdef ADC_DUMP_CHECKSUM_EN
   logic [7:0] checksum;
`endif

   always_comb begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      busy         = 1'b1;
      status       = UART_WIDTH'(8'hB0);
      case (state)
         IDLE: begin
            busy   = 1'b0;
            status = '0;
         end
         DONE: begin
            busy   = 1'b0;
            status = UART_WIDTH'(8'hD0);
         end
         SEND_HI: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = UART_WIDTH'(sample[ADC_WIDTH-1:8]);
         end
         SEND_LO: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = UART_WIDTH'(sample[7:0]);
         end
`ifdef ADC_DUMP_CHECKSUM_EN
         SEND_CK: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = UART_WIDTH'(checksum);
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_is_cmd <= 1'b1;
         counter     <= '0;
         sample      <= '0;
      end else begin
         prev_is_cmd <= (command == DUMP_CMD);
         if (start)                                     counter <= '0;
         else if (state == SEND_LO && xfer && !last)    counter <= counter + ADDR'(1);
         if (state == RD_WAIT) sample <= bus.ram_dout;
      end
   end

`ifdef ADC_DUMP_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                            checksum <= '0;
      else if (start)                                      checksum <= '0;
      else if (xfer && (state == SEND_HI || state == SEND_LO)) checksum <= checksum + bus.tx_data[7:0];
   end
`endif

endmodule

// File: tb/tb_adc_uart_dump.sv
// Scoreboard bench: stimulus pushes expected bytes, a forked monitor pops on every transfer.
module tb_adc_uart_dump;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] command = 8'h00;
   logic       busy;
   logic [7:0] status;

   adc_uart_dump_if #(.UART_WIDTH(8), .ADC_WIDTH(12), .ADDR(2)) bus();

   adc_uart_dump #(.UART_WIDTH(8), .ADC_WIDTH(12), .ADDR(2), .DEPTH(4), .DUMP_CMD(8'h44)) dut (
      .clk     (clk),
      .rst     (rst_n),
      .command (command),
      .bus     (bus),
      .busy    (busy),
      .status  (status)
   );

   always #5 clk = ~clk;

   logic [11:0] mem [4] = '{12'hABC, 12'h001, 12'hF00, 12'h07F};
   always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

   // hand-computed byte stream for the RAM contents above
   logic [7:0] exp_bytes [8] = '{8'h0A, 8'hBC, 8'h00, 8'h01, 8'h0F, 8'h00, 8'h00, 8'h7F};
`ifdef ADC_DUMP_CHECKSUM_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic [7:0] q[$];
   int         xfer_cyc[$];
   int         checks = 0;
   int         fails = 0;
   int         xfer_cnt = 0;
   int         cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_dump();
      logic [7:0] sum = 8'h00;
      for (int i = 0; i < 8; i++) begin
         q.push_back(exp_bytes[i]);
         sum = sum + exp_bytes[i];
      end
`ifdef ADC_DUMP_CHECKSUM_EN
      q.push_back(sum);
`endif
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rst_n && bus.tx_valid) begin
            chk("busy_while_valid", 32'(busy), 32'd1);
            if (q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
               if (bus.tx_ready) xfer_cnt++;
            end else if (bus.tx_ready) begin
               chk("tx_byte", 32'(bus.tx_data), 32'(q.pop_front()));
               xfer_cnt++;
               xfer_cyc.push_back(cyc);
            end else begin
               chk("tx_hold", 32'(bus.tx_data), 32'(q[0]));
            end
         end
      end
   endtask

   task automatic start_edge();
      @(posedge clk); #1 command = 8'h00;
      @(posedge clk); #1 command = 8'h44;
   endtask

   task automatic wait_cnt(input int n);
      int k = 0;
      while (xfer_cnt < n && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      chk("wait_xfer_timeout", 32'(xfer_cnt >= n), 32'd1);
   endtask

   task automatic wait_done();
      int k = 0;
      while (status !== 8'hD0 && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_status", 32'(status), 32'hD0);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_valid", 32'(bus.tx_valid), 32'd0);
   endtask

   initial begin
      int base;
      bus.tx_ready = 1'b1;
      command      = 8'h44;
      fork monitor(); join_none

      // reset state, command held at DUMP_CMD through reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_status", 32'(status), 32'h00);
      chk("rst_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst_data", 32'(bus.tx_data), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("held_no_start", 32'(busy), 32'd0);
      chk("held_no_bytes", 32'(xfer_cnt), 32'd0);

      // first dump, command then held for 50 clk
      start_edge();
      push_dump();
      xfer_cyc.delete();
      @(posedge clk); #1;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_status", 32'(status), 32'hB0);
      repeat (48) @(posedge clk);
      #1;
      chk("d1_status", 32'(status), 32'hD0);
      chk("d1_count", 32'(xfer_cnt), 32'(NB));
      chk("d1_queue_empty", 32'(q.size()), 32'd0);
      chk("d1_last_addr", 32'(bus.ram_addr), 32'd3);
      chk("gap_hi_lo", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);
      chk("gap_sample", 32'(xfer_cyc[2] - xfer_cyc[0]), 32'd4);
      chk("gap_sample3", 32'(xfer_cyc[6] - xfer_cyc[0]), 32'd12);

      // second dump from DONE; an edge mid-dump is ignored
      start_edge();
      push_dump();
      wait_cnt(NB + 2);
      command = 8'h00;
      @(posedge clk); #1 command = 8'h44;
      wait_done();
      chk("d2_count", 32'(xfer_cnt), 32'(2 * NB));
      repeat (10) @(posedge clk);
      #1;
      chk("d2_no_retrigger", 32'(xfer_cnt), 32'(2 * NB));
      chk("d2_queue_empty", 32'(q.size()), 32'd0);

      // tx_ready stall during SEND_LO of sample 1
      base = xfer_cnt;
      start_edge();
      push_dump();
      wait_cnt(base + 3);
      bus.tx_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("stall_no_xfer", 32'(xfer_cnt), 32'(base + 3));
      chk("stall_valid", 32'(bus.tx_valid), 32'd1);
      chk("stall_data", 32'(bus.tx_data), 32'h01);
      bus.tx_ready = 1'b1;
      wait_done();
      chk("d3_count", 32'(xfer_cnt), 32'(base + NB));

      // reset while SEND_HI of sample 2 is waiting
      base = xfer_cnt;
      start_edge();
      push_dump();
      wait_cnt(base + 4);
      bus.tx_ready = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      chk("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
      chk("pre_rst_data", 32'(bus.tx_data), 32'h0F);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.tx_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_status", 32'(status), 32'h00);
      chk("mid_rst_addr", 32'(bus.ram_addr), 32'd0);
      chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
      q.delete();
      bus.tx_ready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_rst_idle", 32'(busy), 32'd0);
      chk("post_rst_no_bytes", 32'(xfer_cnt), 32'(base + 4));
      start_edge();
      push_dump();
      wait_done();
      chk("d5_count", 32'(xfer_cnt), 32'(base + 4 + NB));
      chk("d5_queue_empty", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
